// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encoding,
// settle-counter width and a latency helper for benches.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_t;

  localparam int HOLD_W = 8;

  // Cycles from the accepting edge to the done pulse for n inputs, h hold cycles.
  function automatic int TT_LATENCY(input int n, input int h);
    return (1 << n) * (h + 1) + 1;
  endfunction

endpackage

// File: rtl/tt_hold_counter.sv
// Settle counter: counts cycles a vector has been applied and flags the
// cycle in which the hold time is complete (count == HOLD_CYCLES-1).
module tt_hold_counter
  import tt_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [HOLD_W-1:0] count;

  // Clear has priority over enable so a new vector always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + HOLD_W'(1);
    end
  end

  assign term = (count == HOLD_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks f_in through 0..2^N_IN-1, holds each vector
// HOLD_CYCLES cycles, samples f_y into table_out[f_in] and pulses done.
// Optional build macro TT_COMPARE_EN enables the EXPECTED table compare
// driving mismatch; without it mismatch is constant 0.
module truth_table_sequencer
  import tt_pkg::*;
#(
  parameter int                    N_IN        = 3,
  parameter int                    HOLD_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   f_y,
  output logic [N_IN-1:0]        f_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   table_valid,
  output logic                   mismatch
);

  tt_state_t state, state_nxt;
  logic      cnt_clr;
  logic      cnt_en;
  logic      cnt_term;
  logic      last_vec;
  logic      accept;

  assign accept   = (state == IDLE) && start;
  assign last_vec = (f_in == {N_IN{1'b1}});

  tt_hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and settle-counter control.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = APPLY;
          cnt_clr   = 1'b1;
        end
      end
      APPLY: begin
        cnt_en = 1'b1;
        if (cnt_term) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        cnt_clr   = 1'b1;
        state_nxt = last_vec ? DONE : APPLY;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Vector, table and status registers; done is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_in        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_out   <= '0;
      table_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f_in        <= '0;
            table_out   <= '0;
            table_valid <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SAMPLE: begin
          table_out[f_in] <= f_y;
          // The last vector stays put so f_in never wraps inside a sweep.
          if (!last_vec) begin
            f_in <= f_in + N_IN'(1);
          end
        end
        DONE: begin
          done        <= 1'b1;
          table_valid <= 1'b1;
          busy        <= 1'b0;
          f_in        <= '0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef TT_COMPARE_EN
  logic mismatch_q;

  // Compare runs in DONE, after the last sample has landed in table_out.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      mismatch_q <= 1'b0;
    end else if (state == DONE) begin
      mismatch_q <= (table_out != EXPECTED);
    end
  end

  assign mismatch = mismatch_q;
`else
  // Constant 0; the reduction keeps EXPECTED referenced in this build.
  assign mismatch = &{1'b0, EXPECTED};
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: three instances (defaults, HOLD_CYCLES=1,
// N_IN=2/HOLD_CYCLES=3) driven by boolean functions and random truth tables.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic       f_y_a, f_y_b, f_y_c;
  logic [2:0] f_in_a, f_in_b;
  logic [1:0] f_in_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [7:0] tbl_a, tbl_b;
  logic [3:0] tbl_c;
  logic       tv_a, tv_b, tv_c;
  logic       mm_a, mm_b, mm_c;

  int         sel_a = 0, sel_b = 0, sel_c = 2;
  logic [7:0] rtt_a = '0, rtt_b = '0, rtt_c = '0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] f_in;
    logic       busy;
    logic       done;
    logic       tv;
    logic       mm;
    logic [7:0] tbl;
  } obs_t;

  always #5 clk = ~clk;

  // Function under control: 0=(a&b)|c, 1=a^b^c, 2=a&b (two inputs), 3=lookup table.
  function automatic logic func(input int sel, input logic [7:0] rtt, input logic [2:0] v);
    case (sel)
      0:       return (v[2] & v[1]) | v[0];
      1:       return v[2] ^ v[1] ^ v[0];
      2:       return v[1] & v[0];
      default: return rtt[v];
    endcase
  endfunction

  assign f_y_a = func(sel_a, rtt_a, f_in_a);
  assign f_y_b = func(sel_b, rtt_b, f_in_b);
  assign f_y_c = func(sel_c, rtt_c, {1'b0, f_in_c});

  truth_table_sequencer #(.N_IN(3), .HOLD_CYCLES(2), .EXPECTED(8'hEA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .f_y(f_y_a), .f_in(f_in_a),
    .busy(busy_a), .done(done_a), .table_out(tbl_a), .table_valid(tv_a), .mismatch(mm_a));

  truth_table_sequencer #(.N_IN(3), .HOLD_CYCLES(1), .EXPECTED(8'hE8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .f_y(f_y_b), .f_in(f_in_b),
    .busy(busy_b), .done(done_b), .table_out(tbl_b), .table_valid(tv_b), .mismatch(mm_b));

  truth_table_sequencer #(.N_IN(2), .HOLD_CYCLES(3), .EXPECTED(4'h8)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .f_y(f_y_c), .f_in(f_in_c),
    .busy(busy_c), .done(done_c), .table_out(tbl_c), .table_valid(tv_c), .mismatch(mm_c));

  function automatic obs_t get_obs(input int which);
    obs_t o;
    o = '0;
    case (which)
      0: begin o.f_in = f_in_a; o.busy = busy_a; o.done = done_a; o.tv = tv_a; o.mm = mm_a; o.tbl = tbl_a; end
      1: begin o.f_in = f_in_b; o.busy = busy_b; o.done = done_b; o.tv = tv_b; o.mm = mm_b; o.tbl = tbl_b; end
      default: begin
        o.f_in = {1'b0, f_in_c}; o.busy = busy_c; o.done = done_c; o.tv = tv_c; o.mm = mm_c;
        o.tbl = {4'b0, tbl_c};
      end
    endcase
    return o;
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic set_stim(input int which, input int sel, input logic [7:0] rtt);
    case (which)
      0: begin sel_a = sel; rtt_a = rtt; end
      1: begin sel_b = sel; rtt_b = rtt; end
      default: begin sel_c = sel; rtt_c = rtt; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int which, input obs_t e);
    obs_t o;
    o = get_obs(which);
    chk({tag, ".f_in"}, 32'(o.f_in), 32'(e.f_in));
    chk({tag, ".busy"}, 32'(o.busy), 32'(e.busy));
    chk({tag, ".done"}, 32'(o.done), 32'(e.done));
    chk({tag, ".tv"},   32'(o.tv),   32'(e.tv));
    chk({tag, ".mm"},   32'(o.mm),   32'(e.mm));
    chk({tag, ".tbl"},  32'(o.tbl),  32'(e.tbl));
  endtask

  // Pulse (or hold) start on an idle instance and check every cycle up to done.
  task automatic sweep(input int which, input bit hold, input int sel, input logic [7:0] rtt);
    int n, h, nvec, lat;
    logic [7:0] tt, expv;
    obs_t e;
    n    = (which == 2) ? 2 : 3;
    h    = (which == 0) ? 2 : (which == 1) ? 1 : 3;
    expv = (which == 0) ? 8'hEA : (which == 1) ? 8'hE8 : 8'h08;
    nvec = 1 << n;
    lat  = nvec * (h + 1) + 1;
    set_stim(which, sel, rtt);
    tt = '0;
    for (int i = 0; i < nvec; i++) tt[i] = func(sel, rtt, 3'(i));
    set_start(which, 1'b1);
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 && !hold) set_start(which, 1'b0);
      e = '0;
      if (k < lat) begin
        e.f_in = 3'((k / (h + 1) < nvec - 1) ? k / (h + 1) : nvec - 1);
        e.busy = 1'b1;
        for (int v = 0; v < nvec; v++)
          if ((v + 1) * (h + 1) <= k) e.tbl[v] = tt[v];
      end else begin
        e.done = 1'b1;
        e.tv   = 1'b1;
        e.tbl  = tt;
`ifdef TT_COMPARE_EN
        e.mm = (tt != expv);
`else
        e.mm = 1'b0;
`endif
      end
      chk_all($sformatf("sw%0d_k%0d", which, k), which, e);
    end
  endtask

  initial begin
    obs_t z;
    int   guard;
    logic [7:0] r;
    z = '0;

    // Reset state of all instances.
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_a", 0, z);
    chk_all("rst_b", 1, z);
    chk_all("rst_c", 2, z);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("idle_a", 0, z);

    // Directed functions from the boolean definitions.
    sweep(0, 1'b0, 0, 8'h00);
    chk("tt_and_or", 32'(tbl_a), 32'h EA);
    sweep(1, 1'b0, 1, 8'h00);
    chk("tt_xor3", 32'(tbl_b), 32'h96);
    sweep(2, 1'b0, 2, 8'h00);
    chk("tt_and2", 32'(tbl_c), 32'h8);
    sweep(1, 1'b0, 0, 8'h00);

    // Random truth tables.
    for (int it = 0; it < 4; it++) begin
      r = 8'($urandom);
      sweep(0, 1'b0, 3, r);
      r = 8'($urandom);
      sweep(1, 1'b0, 3, r);
      r = 8'($urandom);
      sweep(2, 1'b0, 3, r);
    end

    // Reset in the middle of a sweep at f_in == 4.
    set_stim(0, 0, 8'h00);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    guard = 0;
    while (f_in_a != 3'd4 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("reach_fin4", 32'(f_in_a), 32'd4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("midrst", 0, z);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("norestart_k%0d", k), {30'd0, done_a, busy_a}, 32'd0);
    end
    sweep(0, 1'b0, 1, 8'h00);
    chk("tt_after_rst", 32'(tbl_a), 32'h96);

    // start held high: one sweep, then re-accept in the IDLE cycle after DONE.
    sweep(0, 1'b1, 0, 8'h00);
    sweep(0, 1'b0, 1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
